// File: rtl/axis_flit_injector.sv
// axis_flit_injector: serializes AXI-Stream beats into LSB-first flits on a credit-based router link.
// Define AXIS_FLIT_INJECTOR_CREDIT_ERR_EN to add a sticky credit over/underflow flag (credit_err).
module axis_flit_injector #(
   parameter int TDATA_WIDTH          = 128,
   parameter int DEST_WIDTH           = 6,
   parameter int SERIALIZATION_FACTOR = 2,
   parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
   parameter int FLIT_BUFFER_DEPTH    = 8,
   parameter int CREDIT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                    clk_noc,
   input  logic                    rst_n,
   input  logic                    axis_tvalid,
   output logic                    axis_tready,
   input  logic [TDATA_WIDTH-1:0]  axis_tdata,
   input  logic                    axis_tlast,
   input  logic [DEST_WIDTH-1:0]   axis_tdest,
   output logic [FLIT_WIDTH-1:0]   data_out,
   output logic [DEST_WIDTH-1:0]   dest_out,
   output logic                    is_tail_out,
   output logic                    send_out,
`ifdef AXIS_FLIT_INJECTOR_CREDIT_ERR_EN
   output logic                    credit_err,
`endif
   input  logic                    credit_in,
   output logic [CREDIT_WIDTH-1:0] credits_avail
);
   localparam int SW = SERIALIZATION_FACTOR > 1 ? $clog2(SERIALIZATION_FACTOR) : 1;
   localparam logic [SW-1:0] LAST_SLICE = SW'(SERIALIZATION_FACTOR - 1);
   localparam logic [CREDIT_WIDTH-1:0] MAX_CRED = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
   typedef enum logic {IDLE, SEND} state_t;
   state_t                  state_q, state_d;
   logic                    rdy_q;
   logic [SW-1:0]           slice_q, slice_d;
   logic [TDATA_WIDTH-1:0]  tdata_q, tdata_d;
   logic [DEST_WIDTH-1:0]   tdest_q, tdest_d;
   logic                    tlast_q, tlast_d;
   logic [CREDIT_WIDTH-1:0] cred_q, cred_d;
   logic [FLIT_WIDTH-1:0]   data_q, data_d;
   logic [DEST_WIDTH-1:0]   dest_q, dest_d;
   logic                    tail_q, tail_d;
   logic                    send_q, send_d;
   logic                    issue, last, accept;
   logic [TDATA_WIDTH-1:0]  shifted;
   // rdy_q keeps tready low until the first edge after reset release
   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         slice_q <= '0;
         tdata_q <= '0;
         tdest_q <= '0;
         tlast_q <= 1'b0;
         cred_q  <= MAX_CRED;
         data_q  <= '0;
         dest_q  <= '0;
         tail_q  <= 1'b0;
         send_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         slice_q <= slice_d;
         tdata_q <= tdata_d;
         tdest_q <= tdest_d;
         tlast_q <= tlast_d;
         cred_q  <= cred_d;
         data_q  <= data_d;
         dest_q  <= dest_d;
         tail_q  <= tail_d;
         send_q  <= send_d;
      end
   end
   always_comb begin
      issue       = state_q == SEND && cred_q != '0;
      last        = slice_q == LAST_SLICE;
      axis_tready = rdy_q && (state_q == IDLE || (issue && last));
      accept      = axis_tvalid && axis_tready;
      shifted     = tdata_q >> (int'(slice_q) * FLIT_WIDTH);
      state_d     = state_q;
      slice_d     = slice_q;
      tdata_d     = tdata_q;
      tdest_d     = tdest_q;
      tlast_d     = tlast_q;
      data_d      = data_q;
      dest_d      = dest_q;
      tail_d      = tail_q;
      send_d      = issue;
      if (issue) begin
         state_d = last ? IDLE : SEND;
         slice_d = last ? '0 : slice_q + SW'(1);
         data_d  = shifted[FLIT_WIDTH-1:0];
         dest_d  = tdest_q;
         tail_d  = tlast_q && last;
      end
      // a beat accepted alongside the previous beat's last flit overrides the return to IDLE
      if (accept) begin
         state_d = SEND;
         slice_d = '0;
         tdata_d = axis_tdata;
         tdest_d = axis_tdest;
         tlast_d = axis_tlast;
      end
      cred_d = (issue && !credit_in) ? cred_q - CREDIT_WIDTH'(1) :
               (!issue && credit_in && cred_q != MAX_CRED) ? cred_q + CREDIT_WIDTH'(1) : cred_q;
   end
   assign data_out      = data_q;
   assign dest_out      = dest_q;
   assign is_tail_out   = tail_q;
   assign send_out      = send_q;
   assign credits_avail = cred_q;
`ifdef AXIS_FLIT_INJECTOR_CREDIT_ERR_EN
   logic err_q;
   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else if ((credit_in && !issue && cred_q == MAX_CRED) || (issue && cred_q == '0)) err_q <= 1'b1;
   end
   assign credit_err = err_q;
`endif
endmodule
